// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Word size, RV32I width codes, FSM encodings and lane helpers
//               shared by the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

    localparam int WORD_SIZE = 32;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;
    localparam logic [1:0] c_ST_ERR    = 2'd3;

    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == c_F3_B) || (f3 == c_F3_H) || (f3 == c_F3_W);
        else
            return (f3 == c_F3_B) || (f3 == c_F3_H) || (f3 == c_F3_W) ||
                   (f3 == c_F3_BU) || (f3 == c_F3_HU);
    endfunction

    // size is funct3[1:0]: 00 byte, 01 halfword, 10 word
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [WORD_SIZE-1:0] store_lanes(input logic [1:0] size,
                                                         input logic [WORD_SIZE-1:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Selects the addressed lane of a read word and sign/zero
//               extends it according to the load width code.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [WORD_SIZE-1:0] i_word,
    input  logic [1:0]           i_addr,
    input  logic [2:0]           i_funct3,
    output logic [WORD_SIZE-1:0] o_data
);

    logic [WORD_SIZE-1:0] w_shifted;

    assign w_shifted = i_word >> {i_addr, 3'b000};

    always_comb begin
        o_data = w_shifted;
        case (i_funct3)
            c_F3_B:  o_data = {{(WORD_SIZE-8){w_shifted[7]}}, w_shifted[7:0]};
            c_F3_H:  o_data = {{(WORD_SIZE-16){w_shifted[15]}}, w_shifted[15:0]};
            c_F3_BU: o_data = {{(WORD_SIZE-8){1'b0}}, w_shifted[7:0]};
            c_F3_HU: o_data = {{(WORD_SIZE-16){1'b0}}, w_shifted[15:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding RV32I load/store unit with alignment
//               checks, lane steering and an access timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req,
    input  logic                 i_we,
    input  logic [2:0]           i_funct3,
    input  logic [WORD_SIZE-1:0] i_addr,
    input  logic [WORD_SIZE-1:0] i_wdata,
    output logic                 o_ready,
    output logic                 o_done,
    output logic [WORD_SIZE-1:0] o_rdata,
    output logic                 o_misaligned,
    output logic                 o_fault,
    output logic [WORD_SIZE-1:0] o_mem_addr,
    output logic [WORD_SIZE-1:0] o_mem_wdata,
    output logic [3:0]           o_mem_be,
    output logic                 o_mem_wen,
    output logic                 o_mem_ren,
    input  logic [WORD_SIZE-1:0] i_mem_rdata,
    input  logic                 i_mem_ready
);

    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_next;
    logic                 r_we;
    logic [2:0]           r_funct3;
    logic [WORD_SIZE-1:0] r_addr;
    logic [WORD_SIZE-1:0] r_wdata;
    logic [7:0]           r_cnt;
    logic                 w_legal;
    logic                 w_mis;
    logic                 w_accept;
    logic                 w_timeout;
    logic [WORD_SIZE-1:0] w_load_data;

    assign w_legal   = funct3_legal(i_we, i_funct3);
    assign w_mis     = is_misaligned(i_funct3[1:0], i_addr[1:0]);
    assign w_accept  = (r_state == c_ST_IDLE) && i_req;
    assign w_timeout = (r_state == c_ST_ACCESS) && !i_mem_ready && (r_cnt == c_CNT_LAST);

    load_align u_load_align (
        .i_word   (i_mem_rdata),
        .i_addr   (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .o_data   (w_load_data)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= c_ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (i_req) w_next = (!w_legal || w_mis) ? c_ST_ERR : c_ST_ACCESS;
            end
            c_ST_ACCESS: begin
                if (i_mem_ready)    w_next = c_ST_RESP;
                else if (w_timeout) w_next = c_ST_ERR;
            end
            default: w_next = c_ST_IDLE;
        endcase
    end

    // Result flags are latched on the transition into RESP/ERR so they are
    // already valid in the o_done cycle and hold until the next completion.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= 8'd0;
            o_rdata      <= '0;
            o_misaligned <= 1'b0;
            o_fault      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we     <= i_we;
                r_funct3 <= i_funct3;
                r_addr   <= i_addr;
                r_wdata  <= i_wdata;
                r_cnt    <= 8'd0;
                if (!w_legal || w_mis) begin
                    o_rdata      <= '0;
                    o_fault      <= !w_legal;
                    o_misaligned <= w_legal && w_mis;
                end
            end
            if (r_state == c_ST_ACCESS) begin
                if (i_mem_ready) begin
                    o_rdata      <= r_we ? '0 : w_load_data;
                    o_fault      <= 1'b0;
                    o_misaligned <= 1'b0;
                end else if (w_timeout) begin
                    o_rdata      <= '0;
                    o_fault      <= 1'b1;
                    o_misaligned <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    always_comb begin
        o_ready     = 1'b0;
        o_done      = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_ren   = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_be    = 4'b0000;
        case (r_state)
            c_ST_IDLE: o_ready = 1'b1;
            c_ST_ACCESS: begin
                o_mem_wen   = r_we;
                o_mem_ren   = !r_we;
                o_mem_addr  = {r_addr[WORD_SIZE-1:2], 2'b00};
                o_mem_be    = byte_enables(r_funct3[1:0], r_addr[1:0]);
                o_mem_wdata = r_we ? store_lanes(r_funct3[1:0], r_wdata) : '0;
            end
            default: o_done = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit against a byte-level
//               memory reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int c_TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ready, done, misaligned, fault, mem_wen, mem_ren;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    logic [7:0]  mem     [0:63];
    logic [7:0]  ref_mem [0:63];
    int          ntot = 0;
    int          nbad = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(c_TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_funct3(funct3),
        .i_addr(addr), .i_wdata(wdata), .o_ready(ready), .o_done(done),
        .o_rdata(rdata), .o_misaligned(misaligned), .o_fault(fault),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
        .o_mem_wen(mem_wen), .o_mem_ren(mem_ren), .i_mem_rdata(mem_rdata),
        .i_mem_ready(mem_ready)
    );

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic legal_of(input logic w, input logic [2:0] f3);
        if (w) return f3 <= 3'd2;
        return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

    function automatic logic mis_of(input logic [2:0] f3, input int a);
        int n;
        n = size_of(f3);
        return (n > 1) && ((a % n) != 0);
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input int a);
        int          n;
        logic [31:0] v;
        n = size_of(f3);
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(a + i) % 64];
        if (!f3[2] && n < 4 && v[8*n-1])
            for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input int a);
        logic [3:0] b;
        b = '0;
        for (int i = 0; i < size_of(f3); i++) b[(a + i) % 4] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] v;
        for (int k = 0; k < 4; k++) v[8*k +: 8] = d[8*(k % size_of(f3)) +: 8];
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input int a, input logic [31:0] d);
        for (int i = 0; i < size_of(f3); i++) ref_mem[(a + i) % 64] = d[8*i +: 8];
    endtask

    // Issues one request and plays the memory side; returns what was observed.
    task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input int delay,
                           output logic rdy_acc, output logic got_done, output int lat,
                           output logic [31:0] rd, output logic mis, output logic flt,
                           output int nstb, output logic wen_seen, output logic ren_seen,
                           output logic bad_stb, output logic [31:0] maddr,
                           output logic [3:0] mbe, output logic [31:0] mwd);
        int waited;
        int base;
        @(negedge clk);
        rdy_acc = ready;
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0; we = $urandom % 2; funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        lat = 1; waited = 0; got_done = 0; nstb = 0; wen_seen = 0; ren_seen = 0;
        bad_stb = 0; maddr = '0; mbe = '0; mwd = '0; rd = '0; mis = 0; flt = 0;
        while (!got_done && lat < 60) begin
            if (done) begin
                got_done = 1; rd = rdata; mis = misaligned; flt = fault;
            end else begin
                if (mem_wen || mem_ren) begin
                    if (mem_wen && mem_ren) bad_stb = 1;
                    if (nstb == 0) begin
                        maddr = mem_addr; mbe = mem_be; mwd = mem_wdata;
                    end else if (mem_addr !== maddr || mem_be !== mbe || mem_wdata !== mwd) begin
                        bad_stb = 1;
                    end
                    nstb++;
                    wen_seen |= mem_wen;
                    ren_seen |= mem_ren;
                    base = int'(mem_addr[5:0]);
                    if (waited == delay) begin
                        mem_ready = 1'b1;
                        for (int k = 0; k < 4; k++) mem_rdata[8*k +: 8] = mem[(base + k) % 64];
                        if (mem_wen)
                            for (int k = 0; k < 4; k++)
                                if (mem_be[k]) mem[(base + k) % 64] = mem_wdata[8*k +: 8];
                    end else begin
                        mem_ready = 1'b0;
                        mem_rdata = $urandom;
                    end
                    waited++;
                end
                @(negedge clk);
                mem_ready = 1'b0;
                lat++;
            end
        end
    endtask

    logic        t_rdy, t_done, t_mis, t_flt, t_wen, t_ren, t_bad;
    int          t_lat, t_nstb;
    logic [31:0] t_rd, t_maddr, t_mwd;
    logic [3:0]  t_mbe;

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        ntot++; if (ready !== 1'b1) begin nbad++; $display("FAIL reset_ready got=%b want=1", ready); end
        ntot++; if ({done, mem_wen, mem_ren, misaligned, fault} !== 5'b0) begin
            nbad++; $display("FAIL reset_flags got=%b want=00000", {done, mem_wen, mem_ren, misaligned, fault}); end
        ntot++; if ({rdata, mem_addr, mem_wdata, mem_be} !== 100'b0) begin
            nbad++; $display("FAIL reset_data got=%h want=0", {rdata, mem_addr, mem_wdata, mem_be}); end
        @(posedge clk); #2 rst = 1'b0;
    endtask

    task automatic test_store_lanes;
        run_req(1'b1, 3'b000, 32'h13, 32'h0000_00A5, 0, t_rdy, t_done, t_lat, t_rd, t_mis, t_flt,
                t_nstb, t_wen, t_ren, t_bad, t_maddr, t_mbe, t_mwd);
        ref_store(3'b000, 32'h13, 32'h0000_00A5);
        ntot++; if (t_rdy !== 1'b1) begin nbad++; $display("FAIL sb_first_accept got=%b want=1", t_rdy); end
        ntot++; if (!t_done || t_lat != 2) begin nbad++; $display("FAIL sb_latency got=%0d done=%b want=2", t_lat, t_done); end
        ntot++; if (t_maddr !== 32'h10) begin nbad++; $display("FAIL sb_addr got=%h want=10", t_maddr); end
        ntot++; if (t_mbe !== 4'b1000) begin nbad++; $display("FAIL sb_be got=%b want=1000", t_mbe); end
        ntot++; if (t_mwd !== 32'hA5A5_A5A5) begin nbad++; $display("FAIL sb_wdata got=%h want=a5a5a5a5", t_mwd); end
        ntot++; if ({t_wen, t_ren, t_bad} !== 3'b100) begin nbad++; $display("FAIL sb_strobe got=%b want=100", {t_wen, t_ren, t_bad}); end
        ntot++; if (t_rd !== 32'h0) begin nbad++; $display("FAIL sb_rdata got=%h want=0", t_rd); end
        run_req(1'b1, 3'b001, 32'h22, 32'h1234_BEEF, 1, t_rdy, t_done, t_lat, t_rd, t_mis, t_flt,
                t_nstb, t_wen, t_ren, t_bad, t_maddr, t_mbe, t_mwd);
        ref_store(3'b001, 32'h22, 32'h1234_BEEF);
        ntot++; if ({t_mbe, t_mwd} !== {4'b1100, 32'hBEEF_BEEF}) begin
            nbad++; $display("FAIL sh_lanes got=%b/%h want=1100/beefbeef", t_mbe, t_mwd); end
        ntot++; if (t_lat != 3 || t_nstb != 2) begin nbad++; $display("FAIL sh_wait got=%0d/%0d want=3/2", t_lat, t_nstb); end
    endtask

    task automatic test_load_extend;
        logic [31:0] held;
        mem[16] = 8'h01; mem[17] = 8'h7F; mem[18] = 8'hFF; mem[19] = 8'h80;
        for (int i = 16; i < 20; i++) ref_mem[i] = mem[i];
        run_req(1'b0, 3'b000, 32'h12, '0, 0, t_rdy, t_done, t_lat, t_rd, t_mis, t_flt,
                t_nstb, t_wen, t_ren, t_bad, t_maddr, t_mbe, t_mwd);
        ntot++; if (t_rd !== 32'hFFFF_FFFF) begin nbad++; $display("FAIL lb_sext got=%h want=ffffffff", t_rd); end
        ntot++; if ({t_mbe, t_wen, t_ren} !== 6'b0100_01) begin nbad++; $display("FAIL lb_be got=%b want=010001", {t_mbe, t_wen, t_ren}); end
        run_req(1'b0, 3'b100, 32'h12, '0, 2, t_rdy, t_done, t_lat, t_rd, t_mis, t_flt,
                t_nstb, t_wen, t_ren, t_bad, t_maddr, t_mbe, t_mwd);
        ntot++; if (t_rd !== 32'h0000_00FF) begin nbad++; $display("FAIL lbu_zext got=%h want=000000ff", t_rd); end
        run_req(1'b0, 3'b001, 32'h12, '0, 0, t_rdy, t_done, t_lat, t_rd, t_mis, t_flt,
                t_nstb, t_wen, t_ren, t_bad, t_maddr, t_mbe, t_mwd);
        ntot++; if (t_rd !== 32'hFFFF_80FF) begin nbad++; $display("FAIL lh_sext got=%h want=ffff80ff", t_rd); end
        held = t_rd;
        @(negedge clk);
        ntot++; if (rdata !== held || done !== 1'b0) begin nbad++; $display("FAIL rdata_hold got=%h/%b want=%h/0", rdata, done, held); end
        run_req(1'b0, 3'b101, 32'h10, '0, 0, t_rdy, t_done, t_lat, t_rd, t_mis, t_flt,
                t_nstb, t_wen, t_ren, t_bad, t_maddr, t_mbe, t_mwd);
        ntot++; if (t_rd !== 32'h0000_7F01) begin nbad++; $display("FAIL lhu_zext got=%h want=00007f01", t_rd); end
    endtask

    task automatic test_misaligned;
        run_req(1'b0, 3'b010, 32'h06, '0, 0, t_rdy, t_done, t_lat, t_rd, t_mis, t_flt,
                t_nstb, t_wen, t_ren, t_bad, t_maddr, t_mbe, t_mwd);
        ntot++; if (!t_done || t_lat != 1) begin nbad++; $display("FAIL lw_mis_latency got=%0d want=1", t_lat); end
        ntot++; if ({t_mis, t_flt, t_nstb != 0} !== 3'b100) begin
            nbad++; $display("FAIL lw_mis_flags got=%b strobes=%0d want=100", {t_mis, t_flt}, t_nstb); end
        run_req(1'b1, 3'b001, 32'h01, 32'h5555, 0, t_rdy, t_done, t_lat, t_rd, t_mis, t_flt,
                t_nstb, t_wen, t_ren, t_bad, t_maddr, t_mbe, t_mwd);
        ntot++; if ({t_mis, t_flt, t_nstb != 0, t_lat == 1} !== 4'b1001) begin
            nbad++; $display("FAIL sh_mis got=%b lat=%0d want=1001", {t_mis, t_flt, t_nstb != 0}, t_lat); end
    endtask

    task automatic test_illegal;
        run_req(1'b0, 3'b011, 32'h00, '0, 0, t_rdy, t_done, t_lat, t_rd, t_mis, t_flt,
                t_nstb, t_wen, t_ren, t_bad, t_maddr, t_mbe, t_mwd);
        ntot++; if ({t_done, t_flt, t_mis, t_nstb != 0} !== 4'b1100 || t_lat != 1) begin
            nbad++; $display("FAIL ld_illegal got=%b lat=%0d want=1100", {t_done, t_flt, t_mis, t_nstb != 0}, t_lat); end
        run_req(1'b1, 3'b110, 32'h05, 32'h1, 0, t_rdy, t_done, t_lat, t_rd, t_mis, t_flt,
                t_nstb, t_wen, t_ren, t_bad, t_maddr, t_mbe, t_mwd);
        ntot++; if ({t_flt, t_mis, t_nstb != 0} !== 3'b100) begin
            nbad++; $display("FAIL st_illegal got=%b want=100", {t_flt, t_mis, t_nstb != 0}); end
    endtask

    task automatic test_timeout;
        run_req(1'b0, 3'b010, 32'h20, '0, 1000, t_rdy, t_done, t_lat, t_rd, t_mis, t_flt,
                t_nstb, t_wen, t_ren, t_bad, t_maddr, t_mbe, t_mwd);
        ntot++; if (t_nstb != c_TO) begin nbad++; $display("FAIL timeout_strobes got=%0d want=%0d", t_nstb, c_TO); end
        ntot++; if ({t_done, t_flt, t_mis} !== 3'b110 || t_lat != c_TO + 1) begin
            nbad++; $display("FAIL timeout_fault got=%b lat=%0d want=110 lat=%0d", {t_done, t_flt, t_mis}, t_lat, c_TO + 1); end
        @(negedge clk);
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h24;
        @(negedge clk); req = 1'b0;
        @(negedge clk);
        ntot++; if (mem_ren !== 1'b1) begin nbad++; $display("FAIL pre_reset_ren got=%b want=1", mem_ren); end
        #2 rst = 1'b1;
        #1;
        ntot++; if ({mem_ren, mem_wen, ready, fault, mem_be} !== 8'b0010_0000) begin
            nbad++; $display("FAIL mid_reset got=%b want=00100000", {mem_ren, mem_wen, ready, fault, mem_be}); end
        @(posedge clk); #2 rst = 1'b0;
        run_req(1'b0, 3'b010, 32'h24, '0, 0, t_rdy, t_done, t_lat, t_rd, t_mis, t_flt,
                t_nstb, t_wen, t_ren, t_bad, t_maddr, t_mbe, t_mwd);
        ntot++; if (!t_rdy || !t_done || t_lat != 2 || t_rd !== exp_load(3'b010, 32'h24)) begin
            nbad++; $display("FAIL after_reset got=%h lat=%0d want=%h lat=2", t_rd, t_lat, exp_load(3'b010, 32'h24)); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            run_req(1'b0, 3'b010, 32'(4 * i), '0, 0, t_rdy, t_done, t_lat, t_rd, t_mis, t_flt,
                    t_nstb, t_wen, t_ren, t_bad, t_maddr, t_mbe, t_mwd);
            ntot++; if (!t_rdy || t_lat != 2 || t_rd !== exp_load(3'b010, 4 * i)) begin
                nbad++; $display("FAIL b2b_%0d got=%h rdy=%b lat=%0d want=%h", i, t_rd, t_rdy, t_lat, exp_load(3'b010, 4 * i)); end
        end
    endtask

    task automatic test_random;
        logic        w;
        logic [2:0]  f3;
        int          a, dly;
        logic [31:0] d;
        for (int it = 0; it < 80; it++) begin
            w = 1'($urandom); f3 = 3'($urandom); a = int'($urandom % 64); d = $urandom; dly = int'($urandom % 4);
            run_req(w, f3, 32'(a), d, dly, t_rdy, t_done, t_lat, t_rd, t_mis, t_flt,
                    t_nstb, t_wen, t_ren, t_bad, t_maddr, t_mbe, t_mwd);
            ntot++;
            if (!legal_of(w, f3)) begin
                if ({t_done, t_flt, t_mis, t_nstb != 0} !== 4'b1100 || t_lat != 1) begin
                    nbad++; $display("FAIL rnd_illegal it=%0d got=%b want=1100", it, {t_done, t_flt, t_mis, t_nstb != 0}); end
            end else if (mis_of(f3, a)) begin
                if ({t_done, t_flt, t_mis, t_nstb != 0} !== 4'b1010 || t_lat != 1) begin
                    nbad++; $display("FAIL rnd_mis it=%0d got=%b want=1010", it, {t_done, t_flt, t_mis, t_nstb != 0}); end
            end else begin
                if ({t_done, t_flt, t_mis, t_bad, t_wen, t_ren} !== {4'b1000, w, !w} ||
                    t_lat != dly + 2 || t_nstb != dly + 1 || t_maddr !== 32'(a & ~3) ||
                    t_mbe !== exp_be(f3, a)) begin
                    nbad++; $display("FAIL rnd_access it=%0d got=%b lat=%0d be=%b addr=%h want=%b lat=%0d be=%b addr=%h",
                                     it, {t_done, t_flt, t_mis, t_bad, t_wen, t_ren}, t_lat, t_mbe, t_maddr,
                                     {4'b1000, w, !w}, dly + 2, exp_be(f3, a), 32'(a & ~3));
                end
                ntot++;
                if (w) begin
                    if (t_mwd !== exp_wd(f3, d) || t_rd !== 32'h0) begin
                        nbad++; $display("FAIL rnd_store it=%0d got=%h/%h want=%h/0", it, t_mwd, t_rd, exp_wd(f3, d)); end
                    ref_store(f3, a, d);
                end else begin
                    if (t_rd !== exp_load(f3, a)) begin
                        nbad++; $display("FAIL rnd_load it=%0d got=%h want=%h", it, t_rd, exp_load(f3, a)); end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_store_lanes();
        test_load_extend();
        test_misaligned();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
